nonce_dispatcher: RTL
=====================

Name: nonce_dispatcher

Overview:
- Scheduler sharing the 32-bit nonce space across NCORES double-SHA-256 mining cores.
- Splits the nonce space into fixed-size chunks and dispatches one chunk per idle core.
- Collects the first valid result, aborts all cores and drains them, or reports exhaustion.
- Sits between the top-level job control and the array of mining cores; header and target reach the cores directly, not through this block.

Parameters:
- NCORES, 4: number of mining cores driven (1..16).
- CHUNK_LOG2, 20: log2 of nonces per chunk; chunk count = 2^(32-CHUNK_LOG2), range 1..31.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- job_start  in  1  pulse; begin a new job (ignored while busy)
- job_abort  in  1  pulse; stop current job
- busy  out  1  high from job accept until drain complete
- done  out  1  one-cycle pulse when job ends (found, exhausted or aborted)
- found  out  1  sticky until next accepted job_start
- found_nonce  out  32  nonce of winning core
- exhausted  out  1  sticky; all chunks searched with no hit
- core_start  out  NCORES  one-cycle start pulse per core
- core_base  out  NCORES*32  registered base nonce per core; stable while that core runs
- core_abort  out  1  one-cycle broadcast abort
- core_busy  in  NCORES  core searching its chunk
- core_found  in  NCORES  one-cycle pulse, qualifies core_nonce
- core_nonce  in  NCORES*32  hit nonce per core

Behaviour:
- Reset: all outputs 0, FSM S_IDLE, chunk counter 0, launched[] 0. Reset mid-job drops the job silently; no done pulse is issued.
- Chunk counter width is 33-CHUNK_LOG2 bits. Chunk k has base k<<CHUNK_LOG2. Last chunk ends at 0xFFFFFFFF with no wrap.
- launched[i]:
  - set in the cycle core_start[i] is pulsed;
  - cleared on the first cycle core_busy[i]==1 is seen.
  - Core i is idle iff !launched[i] && !core_busy[i]. Cores must raise busy within 1 cycle of start.
- S_IDLE:
  - job_start → clear found, exhausted and found_nonce; counter=0; busy=1; go S_RUN.
  - job_abort is ignored.
- S_RUN, per cycle, in priority order:
  1. Any core_found: the lowest index wins. Latch found=1 and found_nonce. Pulse core_abort next cycle. No dispatch this cycle. Go S_DRAIN.
  2. Else job_abort: pulse core_abort. Go S_DRAIN.
  3. Else chunks remain and some core is idle: the lowest-index idle core gets core_base=counter<<CHUNK_LOG2 and a core_start pulse; counter++. At most one dispatch per cycle.
  4. Else no chunks remain and all cores idle: exhausted=1, go S_DONE.
- S_DRAIN: wait until all cores are idle. core_found pulses arriving here are ignored; the first winner stands. Then go S_DONE.
- S_DONE: done=1 for one cycle, busy=0, go S_IDLE.
- job_start while busy is ignored. job_start and job_abort together in S_IDLE: start wins.
- Latency: first core_start 1 cycle after accepted job_start; core k (all idle) starts at cycle k+1.

Decomposition:
- miner_pkg holds:
  - enum sched_state_t {S_IDLE, S_RUN, S_DRAIN, S_DONE};
  - NONCE_W=32.
- One sub-module: prio_first #(N), a combinational lowest-set-bit encoder (valid + index). It is used both for idle-core selection and for found-core selection.

Test Plan:
- NCORES=4, CHUNK_LOG2=20; job_start, cores stay busy → core_start[0..3] on cycles 1..4 with bases 0x00000000, 0x00100000, 0x00200000, 0x00300000; busy=1.
- Same setup; core 2 pulses core_found with 0x0023ABCD → core_abort pulse; after cores drop busy, done pulse; found=1, found_nonce=0x0023ABCD; no further core_start.
- Cores 1 and 3 pulse core_found in the same cycle (0x00112233, 0x00334455) → found_nonce=0x00112233.
- CHUNK_LOG2=30 (4 chunks), NCORES=2, model cores go busy 5 cycles each with no hit:
  - exactly 4 core_start pulses, with bases 0x00000000, 0x40000000, 0x80000000, 0xC0000000;
  - then exhausted=1 and a done pulse.
- job_abort mid-run → core_abort pulse, done after drain, found=0, exhausted=0; a new job_start restarts at base 0.
- Assert rst while busy → all outputs 0 immediately; no done pulse; a later job_start works normally.

Source files
------------

// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared types and constants for the nonce dispatcher
package miner_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nonce_dispatcher_if.sv
// rtl/nonce_dispatcher_if.sv - dispatcher-to-mining-core bundle
interface nonce_dispatcher_if #(
    parameter int NCORES = 4
);
    logic [NCORES-1:0]    core_start;
    logic [NCORES*32-1:0] core_base;
    logic                 core_abort;
    logic [NCORES-1:0]    core_busy;
    logic [NCORES-1:0]    core_found;
    logic [NCORES*32-1:0] core_nonce;

    modport master (
        output core_start, core_base, core_abort,
        input  core_busy, core_found, core_nonce
    );

    modport slave (
        input  core_start, core_base, core_abort,
        output core_busy, core_found, core_nonce
    );
endinterface

// File: rtl/nonce_dispatcher_prio_first.sv
// rtl/nonce_dispatcher_prio_first.sv - lowest-set-bit encoder (valid + index)
module prio_first #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Walking downwards lets the lowest set bit overwrite higher ones.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IW'(i);
        end
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// rtl/nonce_dispatcher.sv - splits the nonce space into chunks and schedules them over the cores
module nonce_dispatcher
    import miner_pkg::*;
#(
    parameter int NCORES     = 4,
    parameter int CHUNK_LOG2 = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_start,
    input  logic               job_abort,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               exhausted,
    nonce_dispatcher_if.master cores
);

    localparam int CW = 33 - CHUNK_LOG2;
    localparam int IW = idx_w(NCORES);

    sched_state_t                   r_state;
    sched_state_t                   w_next;
    logic [CW-1:0]                  r_cnt;
    logic [NCORES-1:0]              r_launched;
    logic [NCORES-1:0]              r_start;
    logic [NCORES-1:0][NONCE_W-1:0] r_base;
    logic                           r_abort;
    logic                           r_found;
    logic [NONCE_W-1:0]             r_found_nonce;
    logic                           r_exhausted;

    logic [NCORES-1:0]              w_idle;
    logic                           w_all_idle;
    logic                           w_chunks_left;
    logic                           w_idle_v;
    logic [IW-1:0]                  w_idle_idx;
    logic                           w_found_v;
    logic [IW-1:0]                  w_found_idx;
    logic [NCORES-1:0][NONCE_W-1:0] w_nonce;
    logic [NONCE_W-1:0]             w_base;
    logic [NCORES-1:0]              w_start_vec;
    logic                           w_accept;
    logic                           w_dispatch;
    logic                           w_set_found;
    logic                           w_abort;
    logic                           w_set_exh;

    assign w_idle        = ~r_launched & ~cores.core_busy;
    assign w_all_idle    = &w_idle;
    // The counter runs one bit past the chunk index, so its MSB marks "all chunks handed out".
    assign w_chunks_left = ~r_cnt[CW-1];
    assign w_nonce       = cores.core_nonce;
    // The dispatch that accompanies job acceptance always hands out chunk 0.
    assign w_base        = w_accept ? '0 : {r_cnt[CW-2:0], {CHUNK_LOG2{1'b0}}};
    assign w_start_vec   = w_dispatch ? (NCORES'(1) << w_idle_idx) : '0;

    prio_first #(.N(NCORES), .IW(IW)) u_idle_sel (
        .i_req   (w_idle),
        .o_valid (w_idle_v),
        .o_idx   (w_idle_idx)
    );

    prio_first #(.N(NCORES), .IW(IW)) u_found_sel (
        .i_req   (cores.core_found),
        .o_valid (w_found_v),
        .o_idx   (w_found_idx)
    );

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_dispatch  = 1'b0;
        w_set_found = 1'b0;
        w_abort     = 1'b0;
        w_set_exh   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (job_start) begin
                    w_accept   = 1'b1;
                    w_dispatch = w_idle_v;
                    w_next     = S_RUN;
                end
            end
            S_RUN: begin
                if (w_found_v) begin
                    w_set_found = 1'b1;
                    w_abort     = 1'b1;
                    w_next      = S_DRAIN;
                end else if (job_abort) begin
                    w_abort = 1'b1;
                    w_next  = S_DRAIN;
                end else if (w_chunks_left && w_idle_v) begin
                    w_dispatch = 1'b1;
                end else if (!w_chunks_left && w_all_idle) begin
                    w_set_exh = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DRAIN: begin
                if (w_all_idle) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_launched    <= '0;
            r_start       <= '0;
            r_base        <= '0;
            r_abort       <= 1'b0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_exhausted   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_start    <= w_start_vec;
            r_abort    <= w_abort;
            r_launched <= (r_launched & ~cores.core_busy) | w_start_vec;
            for (int i = 0; i < NCORES; i++) begin
                if (w_start_vec[i]) r_base[i] <= w_base;
            end
            if (w_accept) begin
                r_cnt         <= w_dispatch ? CW'(1) : '0;
                r_found       <= 1'b0;
                r_found_nonce <= '0;
                r_exhausted   <= 1'b0;
            end else begin
                if (w_dispatch) r_cnt <= r_cnt + CW'(1);
                if (w_set_found) begin
                    r_found       <= 1'b1;
                    r_found_nonce <= w_nonce[w_found_idx];
                end
                if (w_set_exh) r_exhausted <= 1'b1;
            end
        end
    end

    assign busy             = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done             = (r_state == S_DONE);
    assign found            = r_found;
    assign found_nonce      = r_found_nonce;
    assign exhausted        = r_exhausted;
    assign cores.core_start = r_start;
    assign cores.core_base  = r_base;
    assign cores.core_abort = r_abort;

endmodule
